// File: rtl/checkswap_move.sv
// Two-lane pipelined evaluator of the old-vs-new tour length change for a local
// swap / 2-opt move over six points, with Manhattan or squared-Euclidean metric.
module checkswap_move #(
    parameter int CW     = 8,
    parameter int DW     = 32,
    parameter int METRIC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic [1:0]           mode,
    input  logic [CW-1:0]        x0,
    input  logic [CW-1:0]        x1,
    input  logic [CW-1:0]        x2,
    input  logic [CW-1:0]        x3,
    input  logic [CW-1:0]        x4,
    input  logic [CW-1:0]        x5,
    input  logic [CW-1:0]        y0,
    input  logic [CW-1:0]        y1,
    input  logic [CW-1:0]        y2,
    input  logic [CW-1:0]        y3,
    input  logic [CW-1:0]        y4,
    input  logic [CW-1:0]        y5,
    output logic                 busy,
    output logic                 done,
    output logic                 improve,
    output logic signed [DW-1:0] delta,
    output logic                 err
);

    localparam int MIN_DW = ((METRIC != 0) ? 2*CW+2 : CW+1) + 3;

    if (DW < MIN_DW) begin : g_bad_dw
        $fatal(1, "checkswap_move: DW=%0d is below the minimum of %0d", DW, MIN_DW);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_cnt;
    logic [1:0]      r_mode;
    logic [CW-1:0]   r_x [6];
    logic [CW-1:0]   r_y [6];
    logic            r_done;

    logic [CW-1:0]   r_old_dx, r_old_dy, r_new_dx, r_new_dy;
    logic [DW-1:0]   r_old_d, r_new_d;
    logic            r_v1, r_v2;
    logic [DW-1:0]   r_acc_old, r_acc_new;

    logic            w_accept;
    logic [2:0]      w_last_issue;
    logic [2:0]      w_oa, w_ob, w_na, w_nb;
    logic [DW-1:0]   w_diff;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [DW-1:0] metric(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
        logic [DW-1:0] ex, ey;
        ex = DW'(dx);
        ey = DW'(dy);
        return (METRIC != 0) ? ex * ex + ey * ey : ex + ey;
    endfunction

    // busy also covers the registered done cycle, after the FSM is already back in IDLE
    assign busy     = (r_state != S_IDLE) || r_done;
    assign done     = r_done;
    assign w_accept = start && !busy && !clear;
    assign w_diff   = r_acc_old - r_acc_new;

    always_comb begin
        case (r_mode)
            2'd0:    w_last_issue = 3'd2;
            2'd1:    w_last_issue = 3'd1;
            2'd2:    w_last_issue = 3'd3;
            default: w_last_issue = 3'd0;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (mode == 2'd3) ? S_DONE : S_ISSUE;
            S_ISSUE: if (r_cnt == w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == 3'd1) w_next = S_CMP;
            S_CMP:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? 3'd0 : r_cnt + 3'd1;
        end
    end

    // Old lane walks the current edges, new lane the edges after the move.
    always_comb begin
        w_oa = 3'd0; w_ob = 3'd0; w_na = 3'd0; w_nb = 3'd0;
        case ({r_mode, r_cnt})
            {2'd0, 3'd0}: begin w_oa = 3'd0; w_ob = 3'd1; w_na = 3'd0; w_nb = 3'd2; end
            {2'd0, 3'd1}: begin w_oa = 3'd1; w_ob = 3'd2; w_na = 3'd2; w_nb = 3'd1; end
            {2'd0, 3'd2}: begin w_oa = 3'd2; w_ob = 3'd3; w_na = 3'd1; w_nb = 3'd3; end
            {2'd1, 3'd0}: begin w_oa = 3'd0; w_ob = 3'd1; w_na = 3'd0; w_nb = 3'd2; end
            {2'd1, 3'd1}: begin w_oa = 3'd2; w_ob = 3'd3; w_na = 3'd1; w_nb = 3'd3; end
            {2'd2, 3'd0}: begin w_oa = 3'd0; w_ob = 3'd1; w_na = 3'd0; w_nb = 3'd4; end
            {2'd2, 3'd1}: begin w_oa = 3'd1; w_ob = 3'd2; w_na = 3'd4; w_nb = 3'd2; end
            {2'd2, 3'd2}: begin w_oa = 3'd3; w_ob = 3'd4; w_na = 3'd3; w_nb = 3'd1; end
            {2'd2, 3'd3}: begin w_oa = 3'd4; w_ob = 3'd5; w_na = 3'd1; w_nb = 3'd5; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= '0;
            for (int i = 0; i < 6; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else if (w_accept) begin
            r_mode <= mode;
            r_x[0] <= x0; r_x[1] <= x1; r_x[2] <= x2;
            r_x[3] <= x3; r_x[4] <= x4; r_x[5] <= x5;
            r_y[0] <= y0; r_y[1] <= y1; r_y[2] <= y2;
            r_y[3] <= y3; r_y[4] <= y4; r_y[5] <= y5;
        end
    end

    // Clear kills in-flight valids so a request accepted right after cannot pick them up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_old_dx  <= '0; r_old_dy <= '0;
            r_new_dx  <= '0; r_new_dy <= '0;
            r_old_d   <= '0; r_new_d  <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_acc_old <= '0;
            r_acc_new <= '0;
        end else begin
            r_old_dx <= abs_diff(r_x[w_oa], r_x[w_ob]);
            r_old_dy <= abs_diff(r_y[w_oa], r_y[w_ob]);
            r_new_dx <= abs_diff(r_x[w_na], r_x[w_nb]);
            r_new_dy <= abs_diff(r_y[w_na], r_y[w_nb]);
            r_v1     <= (r_state == S_ISSUE) && !clear;
            r_old_d  <= metric(r_old_dx, r_old_dy);
            r_new_d  <= metric(r_new_dx, r_new_dy);
            r_v2     <= r_v1 && !clear;
            if (w_accept) begin
                r_acc_old <= '0;
                r_acc_new <= '0;
            end else if (r_v2) begin
                r_acc_old <= r_acc_old + r_old_d;
                r_acc_new <= r_acc_new + r_new_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta   <= '0;
            improve <= 1'b0;
            err     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE) && !clear;
            if (r_state == S_CMP && !clear) begin
                delta   <= w_diff;
                improve <= !w_diff[DW-1] && (w_diff != '0);
                err     <= 1'b0;
            end else if (r_state == S_DONE && r_mode == 2'd3 && !clear) begin
                delta   <= '0;
                improve <= 1'b0;
                err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_checkswap_move.sv
// Scoreboard bench for checkswap_move: directed moves push expected results,
// per-DUT monitors pop and compare on every done pulse.
module tb_checkswap_move;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start0 = 1'b0, start1 = 1'b0, clear = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [7:0]        px [6];
    logic [7:0]        py [6];
    logic              busy0, done0, improve0, err0;
    logic              busy1, done1, improve1, err1;
    logic signed [31:0] delta0, delta1;

    typedef struct {
        logic signed [31:0] delta;
        logic               improve;
        logic               err;
        int                 lat;
        int                 acc;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t m0, m1;
    int   cyc = 0;
    int   n_vec = 0, n_bad = 0;

    checkswap_move #(.CW(8), .DW(32), .METRIC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .clear(clear), .mode(mode),
        .x0(px[0]), .x1(px[1]), .x2(px[2]), .x3(px[3]), .x4(px[4]), .x5(px[5]),
        .y0(py[0]), .y1(py[1]), .y2(py[2]), .y3(py[3]), .y4(py[4]), .y5(py[5]),
        .busy(busy0), .done(done0), .improve(improve0), .delta(delta0), .err(err0)
    );

    checkswap_move #(.CW(8), .DW(32), .METRIC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .clear(clear), .mode(mode),
        .x0(px[0]), .x1(px[1]), .x2(px[2]), .x3(px[3]), .x4(px[4]), .x5(px[5]),
        .y0(py[0]), .y1(py[1]), .y2(py[2]), .y3(py[3]), .y4(py[4]), .y5(py[5]),
        .busy(busy1), .done(done1), .improve(improve1), .delta(delta1), .err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) check("unexpected_done0", done0, 0);
            else begin
                m0 = q0.pop_front();
                check("delta0", delta0, m0.delta);
                check("improve0", improve0, m0.improve);
                check("err0", err0, m0.err);
                check("latency0", cyc - m0.acc, m0.lat);
            end
        end
        if (done1) begin
            if (q1.size() == 0) check("unexpected_done1", done1, 0);
            else begin
                m1 = q1.pop_front();
                check("delta1", delta1, m1.delta);
                check("improve1", improve1, m1.improve);
                check("err1", err1, m1.err);
                check("latency1", cyc - m1.acc, m1.lat);
            end
        end
    end

    // Points given p0 first: xs = {x0,x1,x2,x3,x4,x5}.
    task automatic set_pts(input logic [47:0] xs, input logic [47:0] ys);
        for (int i = 0; i < 6; i++) begin
            px[i] = xs[47-8*i -: 8];
            py[i] = ys[47-8*i -: 8];
        end
    endtask

    task automatic run(input int which, input logic [1:0] m, input logic [47:0] xs,
                       input logic [47:0] ys, input logic signed [31:0] d,
                       input logic imp, input logic er, input int lat, input bit poke);
        exp_t e;
        int   k;
        @(negedge clk);
        mode = m;
        set_pts(xs, ys);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_after_accept", (which == 0) ? busy0 : busy1, 1);
        e = '{delta: d, improve: imp, err: er, lat: lat, acc: cyc};
        if (which == 0) q0.push_back(e); else q1.push_back(e);
        if (poke) begin
            repeat (2) @(negedge clk);
            start0 = 1'b1;
            mode   = 2'd3;
            @(negedge clk);
            start0 = 1'b0;
            mode   = m;
        end
        k = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && k < 30) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("done_timeout", (which == 0) ? q0.size() : q1.size(), 0);
        q0.delete();
        q1.delete();
        check("busy_after_done", (which == 0) ? busy0 : busy1, 0);
    endtask

    initial begin
        set_pts('0, '0);
        repeat (2) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_delta", delta0, 0);
        check("rst_improve", improve0, 0);
        check("rst_err", err0, 0);
        rst = 1'b0;

        // Manhattan, mode 0 with a start poked while busy
        run(0, 2'd0, {8'd0, 8'd10, 8'd5, 8'd15, 8'd0, 8'd0}, '0, 10, 1, 0, 7, 1);
        // mode 1, then a back-to-back degenerate request
        run(0, 2'd1, {8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd0},
                     {8'd0, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0}, 20, 1, 0, 6, 0);
        run(0, 2'd1, {6{8'd3}}, {6{8'd3}}, 0, 0, 0, 6, 0);
        // reserved mode, then a valid mode clears err; negative delta
        run(0, 2'd3, {8'd9, 8'd1, 8'd7, 8'd2, 8'd0, 8'd0}, '0, 0, 0, 1, 1, 0);
        run(0, 2'd0, {8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0}, '0, -2, 0, 0, 7, 0);
        // mode 2: improving and worsening moves
        run(0, 2'd2, {8'd0, 8'd9, 8'd1, 8'd8, 8'd0, 8'd9},
                     {8'd0, 8'd9, 8'd0, 8'd9, 8'd1, 8'd8}, 62, 1, 0, 8, 0);
        run(0, 2'd2, {8'd0, 8'd5, 8'd5, 8'd0, 8'd10, 8'd10},
                     {8'd0, 8'd0, 8'd5, 8'd5, 8'd0, 8'd5}, -10, 0, 0, 8, 0);

        // squared Euclidean: maximum coordinates, tie; then an improving 2-opt
        run(1, 2'd2, {8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0},
                     {8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 0, 8, 0);
        run(1, 2'd1, {8'd0, 8'd3, 8'd1, 8'd4, 8'd0, 8'd0},
                     {8'd0, 8'd4, 8'd1, 8'd5, 8'd0, 8'd0}, 46, 1, 0, 6, 0);

        // clear at cycle 3 of a mode 2 evaluation
        @(negedge clk);
        mode = 2'd2;
        set_pts({8'd0, 8'd9, 8'd1, 8'd8, 8'd0, 8'd9}, {8'd0, 8'd9, 8'd0, 8'd9, 8'd1, 8'd8});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_busy", busy0, 0);
        check("clear_delta_kept", delta0, -10);
        @(negedge clk);
        clear = 1'b0;
        repeat (12) @(negedge clk);
        check("clear_delta_still", delta0, -10);
        check("clear_busy_idle", busy0, 0);

        // async reset mid-ISSUE after a result that leaves outputs nonzero
        run(0, 2'd2, {8'd0, 8'd9, 8'd1, 8'd8, 8'd0, 8'd9},
                     {8'd0, 8'd9, 8'd0, 8'd9, 8'd1, 8'd8}, 62, 1, 0, 8, 0);
        @(negedge clk);
        mode = 2'd0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy0, 0);
        check("arst_done", done0, 0);
        check("arst_delta", delta0, 0);
        check("arst_improve", improve0, 0);
        check("arst_err", err0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("arst_idle_busy", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/checkswap_move.md
CHECKSWAP_MOVE -- requirements
Module: checkswap_move

Interface
REQ-001 Parameter CW, default 8: coordinate width, unsigned.
REQ-002 Parameter DW, default 32: accumulator and delta width; DW >= (METRIC ? 2*CW+2 : CW+1) + 3 SHALL be checked at elaboration, with a fatal error if violated.
REQ-003 Parameter METRIC, default 0: 0 = Manhattan |dx|+|dy|, 1 = squared Euclidean dx*dx+dy*dy.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request evaluation; accepted only when busy=0.
REQ-007 clear  input  1  synchronous abort of an evaluation in flight.
REQ-008 mode  input  2  0 = adjacent swap, 1 = 2-opt, 2 = non-adjacent swap, 3 = reserved.
REQ-009 x0..x5, y0..y5  input  CW each  points p0..p5; sampled only on the accepting edge.
REQ-010 busy  output  1  evaluation in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 improve  output  1  new tour length strictly shorter than old.
REQ-013 delta  output  DW signed  old_len - new_len, two's complement.
REQ-014 err  output  1  last accepted request had mode 3.

Function
REQ-015 The block SHALL register mode and all 12 coordinates on the edge where start=1, busy=0, clear=0; inputs SHALL be ignored at all other times.
REQ-016 Pair sets: N SHALL be the number of pair issues per request.
- mode 0, N=3: old = d01+d12+d23; new = d02+d21+d13.
- mode 1, N=2: old = d01+d23; new = d02+d13.
- mode 2, N=4: old = d01+d12+d34+d45; new = d04+d42+d31+d15.
REQ-017 Two distance lanes (old, new) SHALL each accept one pair per cycle in a 2-stage pipeline: stage 1 registers |dx| and |dy|; stage 2 registers the metric result.
REQ-018 FSM states SHALL be IDLE -> ISSUE (N cycles, one pair per lane per cycle) -> DRAIN (2 cycles) -> CMP (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-019 The accumulators SHALL clear on accept and add each lane result as it exits the pipeline; all arithmetic SHALL be zero-extended to DW bits with no saturation.
REQ-020 CMP SHALL register delta = old - new and improve = (delta > 0, signed).
REQ-021 done SHALL be high exactly N+4 cycles after the accepting edge (7, 6, 8 for modes 0, 1, 2) and SHALL stay high for one cycle only.
REQ-022 busy SHALL be 1 from the accepting edge through the done cycle inclusive and 0 otherwise; back-to-back requests SHALL be accepted in the cycle after done.
REQ-023 delta, improve and err SHALL hold their values until the next accepted start.
REQ-024 mode 3 SHALL go from IDLE directly to DONE: done pulses 1 cycle after accept, with delta=0, improve=0, err=1; any valid mode SHALL set err=0 at CMP.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 clear=1 SHALL move the block to IDLE on the next edge: busy=0, no done pulse, outputs unchanged; clear takes priority over a simultaneous start.
REQ-027 Identical points SHALL yield delta=0, improve=0 (ties are not improvements).

Reset
REQ-028 While rst=1, outputs SHALL be immediately busy=0, done=0, improve=0, err=0, delta=0, with the FSM in IDLE and accumulators and pipelines zeroed.
REQ-029 Reset asserted mid-evaluation SHALL discard the evaluation; no done SHALL follow the deassertion of reset.

Verification
REQ-030 METRIC=0, mode 0, p0..p3=(0,0),(10,0),(5,0),(15,0) -> done 7 cycles after accept, delta=10, improve=1, err=0.
REQ-031 METRIC=0, mode 1, p0..p3=(0,0),(10,10),(0,10),(10,0) -> done 6 cycles after accept, delta=20, improve=1; then a back-to-back request with all points (3,3) -> delta=0, improve=0.
REQ-032 METRIC=1, CW=8, mode 2, p0=(0,0), p1=(255,255), p2=(0,0), p3=(0,0), p4=(0,0), p5=(0,0) -> done 8 cycles after accept, old=260100, new=260100, delta=0, improve=0.
REQ-033 mode 3 -> done 1 cycle after accept, err=1, delta=0; a following mode 0 request -> err=0.
REQ-034 start pulsed during busy -> ignored, single done; clear at cycle 3 of mode 2 -> busy=0 next cycle, no done, prior delta retained.
REQ-035 rst asserted asynchronously mid-ISSUE -> all outputs 0 without a clock edge; no done within 10 cycles after release.
